itc_raster_counter: RTL and testbench

- Raster position generator that sits directly downstream of the colour-plane sample counter in the clocked video output path.
- Advances horizontal/vertical counters once per `count_sample` pulse; `count_sample` is the completed-pixel strobe from the sample counter.
- Decodes the counters into registered `h_sync`, `v_sync`, `de`, `sof` and `eol` for the video output formatter.
- A small run/stop FSM ensures frames only start and stop on frame boundaries.

---
 rtl/itc_raster_counter_pkg.sv | 32 +++
 rtl/itc_period_counter.sv | 57 +++++
 rtl/itc_raster_counter.sv | 139 +++++++++++++
 tb/tb_itc_raster_counter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/itc_raster_counter_pkg.sv
// Shared types and boundary helpers for the raster position generator.
// Used by itc_period_counter and itc_raster_counter.
package itc_raster_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        RG_ACTIVE,
        RG_FRONT,
        RG_SYNC,
        RG_BACK
    } region_t;

    function automatic int unsigned period_total(input int unsigned active, input int unsigned front,
                                                 input int unsigned sync, input int unsigned back);
        return active + front + sync + back;
    endfunction

    function automatic int unsigned sync_start(input int unsigned active, input int unsigned front);
        return active + front;
    endfunction

    function automatic int unsigned sync_stop(input int unsigned active, input int unsigned front,
                                              input int unsigned sync);
        return active + front + sync;
    endfunction

endpackage

// File: rtl/itc_period_counter.sv
// Wrapping position counter for one raster axis with region decode.
// Region order within the period: active, front porch, sync, back porch.
module itc_period_counter
    import itc_raster_pkg::*;
#(
    parameter int unsigned ACTIVE = 800,
    parameter int unsigned FRONT  = 40,
    parameter int unsigned SYNC   = 128,
    parameter int unsigned BACK   = 88,
    parameter int unsigned WIDTH  = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output region_t          region
);

    localparam int unsigned TOTAL = period_total(ACTIVE, FRONT, SYNC, BACK);
    localparam logic [WIDTH-1:0] LAST        = WIDTH'(TOTAL - 1);
    localparam logic [WIDTH-1:0] FRONT_START = WIDTH'(ACTIVE);
    localparam logic [WIDTH-1:0] SYNC_START  = WIDTH'(sync_start(ACTIVE, FRONT));
    localparam logic [WIDTH-1:0] BACK_START  = WIDTH'(sync_stop(ACTIVE, FRONT, SYNC));

    generate
        if (SYNC == 0) begin : g_bad_sync
            $error("itc_period_counter: SYNC width must be non-zero");
        end
        if (longint'(TOTAL) > (64'd1 << WIDTH)) begin : g_bad_width
            $error("itc_period_counter: WIDTH too small for period total");
        end
    endgenerate

    assign wrap = en && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + WIDTH'(1);
        end
    end

    always_comb begin
        region = RG_BACK;
        if (count < FRONT_START) begin
            region = RG_ACTIVE;
        end else if (count < SYNC_START) begin
            region = RG_FRONT;
        end else if (count < BACK_START) begin
            region = RG_SYNC;
        end
    end

endmodule

// File: rtl/itc_raster_counter.sv
// Raster position generator with registered sync/de/sof/eol decode and run/stop FSM.
// Optional interlaced field indication when ITC_RASTER_FIELD_EN is defined.
module itc_raster_counter
    import itc_raster_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = 800,
    parameter int unsigned H_FRONT   = 40,
    parameter int unsigned H_SYNC    = 128,
    parameter int unsigned H_BACK    = 88,
    parameter int unsigned V_ACTIVE  = 600,
    parameter int unsigned V_FRONT   = 1,
    parameter int unsigned V_SYNC    = 4,
    parameter int unsigned V_BACK    = 23,
    parameter int unsigned CNT_WIDTH = 12,
    parameter int unsigned SYNC_POL  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclr,
    input  logic                 count_sample,
    input  logic                 go,
    input  logic                 stop,
    output logic                 running,
    output logic [CNT_WIDTH-1:0] h_count,
    output logic [CNT_WIDTH-1:0] v_count,
    output logic                 de,
    output logic                 h_sync,
    output logic                 v_sync,
    output logic                 sof,
    output logic                 eol,
    output logic                 field
);

    localparam logic POL = (SYNC_POL != 0);

    state_t  state, state_next;
    region_t h_region, v_region;
    logic    clear, active, h_en, h_wrap, v_wrap;
    logic    vsync_mask, sof_ok;

    assign clear   = rst | sclr;
    assign active  = (state != ST_IDLE);
    assign h_en    = active & count_sample;
    assign running = active;

    itc_period_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .WIDTH  (CNT_WIDTH)
    ) u_h (
        .clk    (clk),
        .rst    (clear),
        .clr    (~active),
        .en     (h_en),
        .count  (h_count),
        .wrap   (h_wrap),
        .region (h_region)
    );

    // Vertical axis advances only on the horizontal wrap; its wrap is the frame wrap.
    itc_period_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .WIDTH  (CNT_WIDTH)
    ) u_v (
        .clk    (clk),
        .rst    (clear),
        .clr    (~active),
        .en     (h_wrap),
        .count  (v_count),
        .wrap   (v_wrap),
        .region (v_region)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (go) state_next = ST_RUN;
            ST_RUN:   if (stop) state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (go) begin
                    state_next = ST_RUN;
                end else if (v_wrap) begin
                    state_next = ST_IDLE;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

`ifdef ITC_RASTER_FIELD_EN
    logic field_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            field_q <= 1'b0;
        end else if (v_wrap) begin
            field_q <= ~field_q;
        end
    end

    assign field      = field_q;
    assign vsync_mask = field_q && (v_count < CNT_WIDTH'(1));
    assign sof_ok     = ~field_q;
`else
    assign field      = 1'b0;
    assign vsync_mask = 1'b0;
    assign sof_ok     = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            de     <= 1'b0;
            h_sync <= ~POL;
            v_sync <= ~POL;
            sof    <= 1'b0;
            eol    <= 1'b0;
        end else begin
            de     <= active && (h_region == RG_ACTIVE) && (v_region == RG_ACTIVE);
            h_sync <= (active && (h_region == RG_SYNC)) ? POL : ~POL;
            v_sync <= (active && (v_region == RG_SYNC) && !vsync_mask) ? POL : ~POL;
            sof    <= h_en && (h_count == '0) && (v_count == '0) && sof_ok;
            eol    <= h_wrap;
        end
    end

endmodule

// File: tb/tb_itc_raster_counter.sv
// Directed bench for itc_raster_counter with a linear-position reference model.
// Honours ITC_RASTER_FIELD_EN when the design is built with it.
module tb_itc_raster_counter;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
`ifdef ITC_RASTER_FIELD_EN
    localparam int FIELD_ON = 1;
`else
    localparam int FIELD_ON = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, sclr, count_sample, go, stop;
    logic        running, de, h_sync, v_sync, sof, eol, field;
    logic [11:0] h_count, v_count;

    always #5 clk = ~clk;

    itc_raster_counter #(
        .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .CNT_WIDTH (12), .SYNC_POL (1)
    ) dut (
        .clk (clk), .rst (rst), .sclr (sclr), .count_sample (count_sample),
        .go (go), .stop (stop), .running (running),
        .h_count (h_count), .v_count (v_count),
        .de (de), .h_sync (h_sync), .v_sync (v_sync),
        .sof (sof), .eol (eol), .field (field)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a single linear pixel position 0..FT-1 and a run mode (0 idle, 1 run, 2 drain).
    int m_mode  = 0;
    int m_pos   = 0;
    bit m_field = 1'b0;
    bit e_de = 1'b0, e_hs = 1'b0, e_vs = 1'b0, e_sof = 1'b0, e_eol = 1'b0;
    bit checking = 1'b0;

    always @(posedge clk) begin : model
        int h, v;
        bit on, pulse, wrap;
        h     = m_pos % HT;
        v     = m_pos / HT;
        on    = (m_mode != 0);
        pulse = on && count_sample;
        wrap  = pulse && (m_pos == FT - 1);
        if (rst || sclr) begin
            m_mode <= 0; m_pos <= 0; m_field <= 1'b0;
            e_de <= 1'b0; e_hs <= 1'b0; e_vs <= 1'b0; e_sof <= 1'b0; e_eol <= 1'b0;
        end else begin
            e_de  <= on && h < HA && v < VA;
            e_hs  <= on && h >= HA + HF && h < HA + HF + HS;
            e_vs  <= on && v >= VA + VF && v < VA + VF + VS && !(m_field && v < 1);
            e_sof <= pulse && m_pos == 0 && !m_field;
            e_eol <= pulse && h == HT - 1;
            if (pulse) m_pos <= (m_pos + 1) % FT;
            if (FIELD_ON != 0 && wrap) m_field <= !m_field;
            case (m_mode)
                0: if (go) m_mode <= 1;
                1: if (stop) m_mode <= 2;
                default: begin
                    if (go) m_mode <= 1;
                    else if (wrap) m_mode <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("h_count", h_count, m_pos % HT);
            check("v_count", v_count, m_pos / HT);
            check("running", running, m_mode != 0);
            check("de", de, e_de);
            check("h_sync", h_sync, e_hs);
            check("v_sync", v_sync, e_vs);
            check("sof", sof, e_sof);
            check("eol", eol, e_eol);
            check("field", field, m_field);
        end
    end

    int sof_seen, eol_seen, de_seen, hs_seen, vs_seen;

    task automatic clear_seen();
        sof_seen = 0; eol_seen = 0; de_seen = 0; hs_seen = 0; vs_seen = 0;
    endtask

    task automatic tick(input logic c, input logic g, input logic s);
        count_sample = c; go = g; stop = s;
        @(negedge clk);
        sof_seen += int'(sof); eol_seen += int'(eol); de_seen += int'(de);
        hs_seen  += int'(h_sync); vs_seen += int'(v_sync);
    endtask

    task automatic pulses(input int n);
        repeat (n) tick(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; sclr = 1'b0; count_sample = 1'b0; go = 1'b0; stop = 1'b0;
        clear_seen();
        @(negedge clk);
        checking = 1'b1;
        @(negedge clk);
        check("rst_h", h_count, 0);
        check("rst_v", v_count, 0);
        check("rst_de", de, 0);
        check("rst_hsync", h_sync, 0);
        check("rst_running", running, 0);
        rst = 1'b0;

        // Continuous pixels over two frames
        tick(1'b0, 1'b1, 1'b0);
        check("go_running", running, 1);
        check("go_first_h", h_count, 0);
        clear_seen();
        pulses(2 * FT);
        check("s1_sof_count", sof_seen, FIELD_ON != 0 ? 1 : 2);
        check("s1_de_count", de_seen, 24);
        check("s1_hs_count", hs_seen, 24);
        check("s1_vs_count", vs_seen, 16);
        check("s1_eol_count", eol_seen, 12);

        // Sparse pixels, every third cycle
        clear_seen();
        for (int k = 0; k < 72; k++) tick(k % 3 == 0, 1'b0, 1'b0);
        check("s2_eol_count", eol_seen, 3);
        check("s2_h", h_count, 0);
        check("s2_v", v_count, 3);

        // Stop mid-frame, frame drains to completion
        pulses(34);
        check("s3_stop_h", h_count, 2);
        check("s3_stop_v", v_count, 1);
        tick(1'b0, 1'b0, 1'b1);
        pulses(37);
        check("s3_last_h", h_count, 7);
        check("s3_last_v", v_count, 5);
        check("s3_last_running", running, 1);
        pulses(1);
        check("s3_idle_running", running, 0);
        pulses(10);
        check("s3_idle_h", h_count, 0);
        check("s3_idle_v", v_count, 0);

        // Stop, then go during drain
        tick(1'b0, 1'b1, 1'b0);
        pulses(5);
        tick(1'b0, 1'b0, 1'b1);
        pulses(3);
        tick(1'b0, 1'b1, 1'b0);
        clear_seen();
        pulses(41);
        check("s4_sof_count", sof_seen, 1);
        check("s4_running", running, 1);
        check("s4_h", h_count, 1);

        // go and stop together in drain: go wins
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        pulses(47);
        check("s4_prio_running", running, 1);

        // Synchronous clear mid-frame
        pulses(19);
        check("s5_h", h_count, 3);
        check("s5_v", v_count, 2);
        sclr = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        sclr = 1'b0;
        check("s5_clr_h", h_count, 0);
        check("s5_clr_v", v_count, 0);
        check("s5_clr_de", de, 0);
        check("s5_clr_hsync", h_sync, 0);
        check("s5_clr_vsync", v_sync, 0);
        check("s5_clr_running", running, 0);
        pulses(5);
        check("s5_idle_h", h_count, 0);

        // Field sequencing across two frames
        tick(1'b0, 1'b1, 1'b0);
        check("s6_field0", field, 0);
        clear_seen();
        pulses(FT);
        check("s6_sof_f0", sof_seen, 1);
        check("s6_field1", field, FIELD_ON != 0 ? 1 : 0);
        clear_seen();
        pulses(FT);
        check("s6_sof_f1", sof_seen, FIELD_ON != 0 ? 0 : 1);
        tick(1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
